hdb3_enc_seq: RTL and testbench

Frame sequencer in front of the HDB3 encoder chain (NRZ map → V insertion → B insertion → polarity). It pulls payload bits from a source through a prefetch FIFO and feeds the chain one 2-bit symbol code per clock. It drains the chain with zero codes at end of frame. It re-aligns valid, start-of-frame and end-of-frame tags with the coded symbols returned by the chain. Symbol codes across the codebase: 00 zero, 01 one, 11 V, 10 B.

---
 rtl/hdb3_enc_seq_pkg.sv | 27 ++
 rtl/hdb3_enc_seq_fifo.sv | 73 +++++++
 rtl/hdb3_enc_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_hdb3_enc_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdb3_enc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdb3_pkg
// Purpose  : Shared definitions for the HDB3 encoder codebase. Holds the
//            2-bit symbol codes used on every code bus and the frame
//            sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package hdb3_pkg;

    // Symbol codes carried on all 2-bit code buses
    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_ONE  = 2'b01;
    localparam logic [1:0] CODE_V    = 2'b11;
    localparam logic [1:0] CODE_B    = 2'b10;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_SEND    = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/hdb3_enc_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hdb3_seq_fifo
// Purpose  : 1-bit synchronous prefetch FIFO, first-word fall-through read.
//            Push and pop in the same cycle leave the count unchanged.
// Ports    : clk, rst (async, active-high)
//            i_push/i_din  - write strobe and data (ignored when full)
//            i_pop         - read strobe (ignored when empty)
//            o_dout        - head-of-queue bit
//            o_count       - current fill level (0..DEPTH)
//            o_full/o_empty- status flags
// Revision : 1.0 - initial release
// ============================================================================
module hdb3_seq_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_din,
    input  logic                     i_pop,
    output logic                     o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdb3_enc_seq.sv
`default_nettype none
// ============================================================================
// Module   : hdb3_enc_seq
// Purpose  : Frame sequencer in front of the HDB3 encoder chain. Prefetches
//            payload bits into a FIFO, feeds the chain one code per clock,
//            drains it with zero codes at frame end and re-aligns the
//            valid/sof/eof tags with the codes returned by the chain.
// Ports    : clk, rst (async, active-high)
//            start, frame_len        - frame request (sampled in IDLE)
//            s_valid, s_data, s_ready- payload source handshake
//            enc_din / enc_dout      - encoder chain input / output codes
//            m_code, m_valid, m_sof, m_eof - aligned line symbol stream
//            busy, done, err_underrun- status
//            v_count, b_count        - per-frame V / B symbol counts
// Config   : HDB3_SEQ_STATS_EN - when defined, v_count/b_count are live
//            saturating counters; otherwise both are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hdb3_enc_seq
    import hdb3_pkg::*;
#(
    parameter int PIPE_LAT = 5,
    parameter int LEN_W    = 16,
    parameter int DEPTH    = 8,
    parameter int PREFILL  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             s_valid,
    input  logic             s_data,
    output logic             s_ready,
    output logic [1:0]       enc_din,
    input  logic [1:0]       enc_dout,
    output logic [1:0]       m_code,
    output logic             m_valid,
    output logic             m_sof,
    output logic             m_eof,
    output logic             busy,
    output logic             done,
    output logic             err_underrun,
    output logic [LEN_W-1:0] v_count,
    output logic [LEN_W-1:0] b_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = $clog2(PIPE_LAT + 1);
    localparam logic [LEN_W-1:0] c_prefill_len = LEN_W'(PREFILL);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;

    logic             w_start_acc;
    logic             w_push;
    logic             w_pop;
    logic             w_last_pop;
    logic             w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW-1:0]    w_fifo_count;
    logic [LEN_W-1:0] w_prefill_target;

    logic [LEN_W-1:0] r_fetch_left;
    logic [LEN_W-1:0] r_send_left;
    logic [FW-1:0]    r_flush_cnt;
    logic             r_first;
    logic [1:0]       r_enc_din;
    logic             r_tag_v;
    logic             r_tag_sof;
    logic             r_tag_eof;
    logic             r_err;

    logic [PIPE_LAT-1:0] r_v_dly;
    logic [PIPE_LAT-1:0] r_sof_dly;
    logic [PIPE_LAT-1:0] r_eof_dly;

    // ------------------------------------------------------------------
    // Handshake / pop decisions
    // ------------------------------------------------------------------
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign s_ready     = ((r_state == ST_PREFILL) || (r_state == ST_SEND)) &&
                         !w_fifo_full && (r_fetch_left != '0);
    assign w_push      = s_valid && s_ready;
    assign w_pop       = (r_state == ST_SEND) && !w_fifo_empty;
    assign w_last_pop  = w_pop && (r_send_left == LEN_W'(1));

    // No bits have been popped during PREFILL, so send_left still holds
    // frame_len; short frames only wait for their own length.
    assign w_prefill_target = (r_send_left < c_prefill_len) ? r_send_left
                                                            : c_prefill_len;

    hdb3_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (s_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (frame_len == '0) ? ST_DONE : ST_PREFILL;
                end
            end
            ST_PREFILL: begin
                if (LEN_W'(w_fifo_count) >= w_prefill_target) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_last_pop) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == FW'(PIPE_LAT - 1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame counters, chain input code and slot tags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_left <= '0;
            r_send_left  <= '0;
            r_flush_cnt  <= '0;
            r_first      <= 1'b0;
            r_enc_din    <= CODE_ZERO;
            r_tag_v      <= 1'b0;
            r_tag_sof    <= 1'b0;
            r_tag_eof    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_fetch_left <= frame_len;
            end else if (w_push) begin
                r_fetch_left <= r_fetch_left - LEN_W'(1);
            end

            if (w_start_acc) begin
                r_send_left <= frame_len;
            end else if (w_pop) begin
                r_send_left <= r_send_left - LEN_W'(1);
            end

            if (w_start_acc) begin
                r_first <= 1'b1;
            end else if (w_pop) begin
                r_first <= 1'b0;
            end

            if (r_state == ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + FW'(1);
            end else begin
                r_flush_cnt <= '0;
            end

            // Filler slots (prefill, underrun, flush, idle) carry zero code
            r_enc_din <= w_pop ? {1'b0, w_fifo_dout} : CODE_ZERO;
            r_tag_v   <= w_pop;
            r_tag_sof <= w_pop && r_first;
            r_tag_eof <= w_last_pop;

            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if ((r_state == ST_SEND) && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag delay line: matches the chain latency so tags meet enc_dout
    // ------------------------------------------------------------------
    generate
        if (PIPE_LAT == 1) begin : g_dly_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v_dly   <= '0;
                    r_sof_dly <= '0;
                    r_eof_dly <= '0;
                end else begin
                    r_v_dly   <= r_tag_v;
                    r_sof_dly <= r_tag_sof;
                    r_eof_dly <= r_tag_eof;
                end
            end
        end else begin : g_dly_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v_dly   <= '0;
                    r_sof_dly <= '0;
                    r_eof_dly <= '0;
                end else begin
                    r_v_dly   <= {r_v_dly[PIPE_LAT-2:0],   r_tag_v};
                    r_sof_dly <= {r_sof_dly[PIPE_LAT-2:0], r_tag_sof};
                    r_eof_dly <= {r_eof_dly[PIPE_LAT-2:0], r_tag_eof};
                end
            end
        end
    endgenerate

    assign enc_din      = r_enc_din;
    assign m_code       = enc_dout;
    assign m_valid      = r_v_dly[PIPE_LAT-1];
    assign m_sof        = r_sof_dly[PIPE_LAT-1];
    assign m_eof        = r_eof_dly[PIPE_LAT-1];
    assign err_underrun = r_err;

    // ------------------------------------------------------------------
    // Optional per-frame V/B statistics
    // ------------------------------------------------------------------
`ifdef HDB3_SEQ_STATS_EN
    logic [LEN_W-1:0] r_v_cnt;
    logic [LEN_W-1:0] r_b_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v_cnt <= '0;
            r_b_cnt <= '0;
        end else if (w_start_acc) begin
            r_v_cnt <= '0;
            r_b_cnt <= '0;
        end else if (m_valid) begin
            if ((enc_dout == CODE_V) && (r_v_cnt != '1)) begin
                r_v_cnt <= r_v_cnt + LEN_W'(1);
            end
            if ((enc_dout == CODE_B) && (r_b_cnt != '1)) begin
                r_b_cnt <= r_b_cnt + LEN_W'(1);
            end
        end
    end

    assign v_count = r_v_cnt;
    assign b_count = r_b_cnt;
`else
    assign v_count = '0;
    assign b_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdb3_enc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdb3_enc_seq
// Purpose  : Directed self-checking bench for hdb3_enc_seq. Includes a
//            behavioural HDB3 encoder chain (5-cycle latency, 000V / B00V
//            substitution by parity of pulses since the last V).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdb3_enc_seq;

    localparam int PIPE_LAT = 5;
    localparam int LEN_W    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             s_valid;
    logic             s_data;
    logic             s_ready;
    logic [1:0]       enc_din;
    logic [1:0]       enc_dout;
    logic [1:0]       m_code;
    logic             m_valid;
    logic             m_sof;
    logic             m_eof;
    logic             busy;
    logic             done;
    logic             err_underrun;
    logic [LEN_W-1:0] v_count;
    logic [LEN_W-1:0] b_count;

    always #5 clk = ~clk;

    hdb3_enc_seq #(
        .PIPE_LAT (PIPE_LAT),
        .LEN_W    (LEN_W),
        .DEPTH    (8),
        .PREFILL  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_len    (frame_len),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .enc_din      (enc_din),
        .enc_dout     (enc_dout),
        .m_code       (m_code),
        .m_valid      (m_valid),
        .m_sof        (m_sof),
        .m_eof        (m_eof),
        .busy         (busy),
        .done         (done),
        .err_underrun (err_underrun),
        .v_count      (v_count),
        .b_count      (b_count)
    );

    // ------------------------------------------------------------------
    // Encoder chain model: 4-deep window plus output register
    // ------------------------------------------------------------------
    logic [1:0] ch_sr [4];
    logic [1:0] ch_out;
    logic [1:0] ch_x;
    logic [1:0] ch_b;
    int         ch_run;
    int         ch_run_n;
    logic       ch_par;
    logic       ch_par_n;

    always_comb begin
        ch_x     = enc_din;
        ch_b     = ch_sr[2];
        ch_run_n = ch_run;
        ch_par_n = ch_par;
        if (enc_din == 2'b00) begin
            if (ch_run == 3) begin
                ch_x     = 2'b11;
                if (!ch_par) ch_b = 2'b10;
                ch_par_n = 1'b0;
                ch_run_n = 0;
            end else begin
                ch_run_n = ch_run + 1;
            end
        end else begin
            ch_run_n = 0;
            ch_par_n = ~ch_par;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ch_sr[i] <= 2'b00;
            ch_out <= 2'b00;
            ch_run <= 0;
            ch_par <= 1'b0;
        end else begin
            ch_out   <= ch_sr[3];
            ch_sr[3] <= ch_b;
            ch_sr[2] <= ch_sr[1];
            ch_sr[1] <= ch_sr[0];
            ch_sr[0] <= ch_x;
            ch_run   <= ch_run_n;
            ch_par   <= ch_par_n;
        end
    end

    assign enc_dout = ch_out;

    // ------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------
    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    int idx, k0;
    int cur_len, cur_hold, cur_resume;
    logic [15:0] cur_bits;
    int nvalid, nsof, neof, ndone, nbusy, nover, nbval, nvval;
    int first_v, last_v, sof_cyc, eof_cyc, done_cyc;
    logic [1:0] codes [32];

    task automatic check(input string tag, input int obs, input int exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_log();
        nvalid = 0; nsof = 0; neof = 0; ndone = 0; nbusy = 0; nover = 0;
        nbval = 0; nvval = 0;
        first_v = -1; last_v = -1; sof_cyc = -1; eof_cyc = -1; done_cyc = -1;
        for (int i = 0; i < 32; i++) codes[i] = 2'b00;
    endtask

    task automatic drive_src();
        s_valid = (idx < cur_len) && ((idx < cur_hold) || (cyc >= cur_resume));
        s_data  = (idx < 16) ? cur_bits[idx] : 1'b0;
    endtask

    task automatic log_outputs();
        if (m_valid) begin
            if (nvalid < 32) codes[nvalid] = m_code;
            if (nvalid == 0) first_v = cyc;
            last_v = cyc;
            nvalid++;
            if (m_code == 2'b10) nbval++;
            if (m_code == 2'b11) nvval++;
        end
        if (m_sof) begin nsof++; sof_cyc = cyc; end
        if (m_eof) begin neof++; eof_cyc = cyc; end
        if (done)  begin ndone++; done_cyc = cyc; end
        if (busy)  nbusy++;
        if (s_ready && (idx >= cur_len)) nover++;
    endtask

    task automatic step();
        logic hs;
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) idx++;
        drive_src();
        log_outputs();
    endtask

    task automatic launch(input int len, input logic [15:0] bits,
                          input int hold, input int resume_off);
        clear_log();
        cur_len    = len;
        cur_bits   = bits;
        cur_hold   = hold;
        idx        = 0;
        k0         = cyc;
        cur_resume = k0 + resume_off;
        frame_len  = LEN_W'(len);
        start      = 1'b1;
        drive_src();
        step();
        start = 1'b0;
    endtask

    task automatic run_frame(input int len, input logic [15:0] bits,
                             input int hold, input int resume_off);
        launch(len, bits, hold, resume_off);
        for (int i = 0; i < 80 && ndone == 0; i++) step();
        repeat (3) step();
    endtask

    logic [1:0] exp8 [8];
    logic [1:0] exp3 [3];

    initial begin
        exp8 = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
        exp3 = '{2'b01, 2'b01, 2'b10};
        rst = 1'b1; start = 1'b0; frame_len = '0; s_valid = 1'b0; s_data = 1'b0;
        cur_len = 0; cur_hold = 0; cur_resume = 0; cur_bits = '0; idx = 0; k0 = 0;
        clear_log();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",    int'(busy), 0);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_enc_din", int'(enc_din), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_done",    int'(done), 0);
        check("rst_err",     int'(err_underrun), 0);
        rst = 1'b0;
        repeat (6) step();

        // Frame of 8: bits 1,0,1,1,0,0,0,0
        run_frame(8, 16'h000D, 8, 0);
        check("f8_done_cnt",  ndone, 1);
        check("f8_nvalid",    nvalid, 8);
        check("f8_contig",    last_v - first_v, 7);
        check("f8_nsof",      nsof, 1);
        check("f8_neof",      neof, 1);
        check("f8_sof_first", sof_cyc, first_v);
        check("f8_eof_last",  eof_cyc, last_v);
        check("f8_sof_time",  sof_cyc - k0, 12);
        check("f8_done_time", done_cyc - k0, 19);
        check("f8_done_eof",  done_cyc, eof_cyc);
        check("f8_busy_cyc",  nbusy, 19);
        check("f8_err",       int'(err_underrun), 0);
        check("f8_overfetch", nover, 0);
        for (int i = 0; i < 8; i++) check("f8_code", int'(codes[i]), int'(exp8[i]));

        // Empty frame
        run_frame(0, 16'h0000, 0, 0);
        check("f0_done_cnt",  ndone, 1);
        check("f0_done_time", done_cyc - k0, 1);
        check("f0_busy_cyc",  nbusy, 1);
        check("f0_nvalid",    nvalid, 0);

        // Frame of 10 with source stalled until 3 filler slots have gone
        run_frame(10, 16'h016F, 4, 12);
        check("f10_nvalid",    nvalid, 10);
        check("f10_span",      eof_cyc - sof_cyc, 12);
        check("f10_sof_time",  sof_cyc - k0, 12);
        check("f10_done_time", done_cyc - k0, 24);
        check("f10_neof",      neof, 1);
        check("f10_err",       int'(err_underrun), 1);

        // Short frame (3 < PREFILL): tail zero becomes B from flush zeros
        run_frame(3, 16'h0003, 3, 0);
        check("f3_sof_time",  sof_cyc - k0, 11);
        check("f3_eof_time",  eof_cyc - k0, 13);
        check("f3_done_time", done_cyc - k0, 13);
        check("f3_overfetch", nover, 0);
        check("f3_nvalid",    nvalid, 3);
        check("f3_err_clr",   int'(err_underrun), 0);
        for (int i = 0; i < 3; i++) check("f3_code", int'(codes[i]), int'(exp3[i]));

        // Reset in the middle of SEND
        launch(8, 16'h000D, 8, 0);
        repeat (8) step();
        check("mr_busy_pre", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("mr_busy",    int'(busy), 0);
        check("mr_s_ready", int'(s_ready), 0);
        check("mr_enc_din", int'(enc_din), 0);
        check("mr_m_valid", int'(m_valid), 0);
        check("mr_sof_eof", int'({m_sof, m_eof}), 0);
        check("mr_done",    int'(done), 0);
        check("mr_err",     int'(err_underrun), 0);
        check("mr_vb",      int'(v_count) + int'(b_count), 0);
        step();
        rst = 1'b0;
        clear_log();
        repeat (20) step();
        check("mr_no_done", ndone, 0);
        check("mr_no_eof",  neof, 0);
        run_frame(8, 16'h000D, 8, 0);
        check("mr_f8_nvalid", nvalid, 8);
        check("mr_f8_done",   done_cyc - k0, 19);
        for (int i = 0; i < 8; i++) check("mr_f8_code", int'(codes[i]), int'(exp8[i]));

        // All-zero frame of 12: statistics
        run_frame(12, 16'h0000, 12, 0);
        check("f12_nvalid", nvalid, 12);
        check("f12_nv_seen", nvval, 3);
`ifdef HDB3_SEQ_STATS_EN
        check("f12_v_count", int'(v_count), 3);
        check("f12_b_count", int'(b_count), nbval);
`else
        check("f12_v_count", int'(v_count), 0);
        check("f12_b_count", int'(b_count), 0);
`endif
        repeat (5) step();
`ifdef HDB3_SEQ_STATS_EN
        check("f12_v_hold", int'(v_count), 3);
`else
        check("f12_v_hold", int'(v_count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
